// File: rtl/weight_fifo_ring.sv
// weight_fifo_ring: circular weight-row FIFO (write ready/valid, 1-cycle pop into rd_data_o/rd_valid_o/tile_last_o, count/full/empty/almost_full status, flush)
module weight_fifo_ring #(
  parameter int DATA_W    = 8,
  parameter int LANES     = 32,
  parameter int DEPTH     = 128,
  parameter int TILE_ROWS = 32,
  parameter int AF_MARGIN = 4,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [DATA_W-1:0] wr_data_i [LANES],
  input  logic              rd_en_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o [LANES],
  output logic              tile_last_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = TILE_ROWS > 1 ? $clog2(TILE_ROWS) : 1;
  localparam int RW = LANES * DATA_W;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [TW-1:0] LAST_TILE = TW'(TILE_ROWS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT = CNT_W'(DEPTH - AF_MARGIN);
  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] wr_row, rd_row;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] tile;
  logic          accept, pop;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign wr_row[g*DATA_W +: DATA_W] = wr_data_i[g];
    assign rd_data_o[g] = rd_row[g*DATA_W +: DATA_W];
  end
  assign full_o        = count_o == FULL_CNT;
  assign empty_o       = count_o == '0;
  assign almost_full_o = count_o >= AF_CNT;
  assign wr_ready_o    = !full_o;
  assign accept        = wr_valid_i && wr_ready_o;
  assign pop           = rd_en_i && !empty_o;
  always_ff @(posedge clk_i)
    if (accept) mem[wr_ptr] <= wr_row;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_o     <= '0;
      tile        <= '0;
      rd_valid_o  <= 1'b0;
      tile_last_o <= 1'b0;
      rd_row      <= '0;
    end else if (flush_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_o     <= '0;
      tile        <= '0;
      rd_valid_o  <= 1'b0;
      tile_last_o <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr == LAST_PTR ? '0 : wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr == LAST_PTR ? '0 : rd_ptr + 1'b1;
        tile   <= tile == LAST_TILE ? '0 : tile + 1'b1;
        rd_row <= mem[rd_ptr];
      end
      rd_valid_o  <= pop;
      tile_last_o <= pop && tile == LAST_TILE;
      count_o     <= count_o + CNT_W'(accept) - CNT_W'(pop);
    end
  end
endmodule

// File: tb/tb_weight_fifo_ring.sv
// tb_weight_fifo_ring: directed stimulus with a queue-based reference model compared every cycle plus literal spot checks
module tb_weight_fifo_ring;
  localparam int DATA_W = 8, LANES = 32, DEPTH = 128, TILE_ROWS = 32, AF_MARGIN = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int RW = LANES * DATA_W;
  typedef logic [RW-1:0] row_t;
  logic clk = 0, rst = 1, flush = 0, wr_valid = 0, rd_en = 0;
  logic wr_ready, rd_valid, tile_last, full, empty, almost_full;
  logic [DATA_W-1:0] wr_data [LANES];
  logic [DATA_W-1:0] rd_data [LANES];
  logic [CNT_W-1:0] count;
  int passed = 0, total = 0;
  bit chk_en = 0;
  row_t mq[$];
  int mtile = 0;
  logic mrv = 0, mtl = 0;
  row_t mdata = '0;
  weight_fifo_ring #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH), .TILE_ROWS(TILE_ROWS), .AF_MARGIN(AF_MARGIN)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .tile_last_o(tile_last), .count_o(count), .full_o(full), .empty_o(empty), .almost_full_o(almost_full));
  always #5 clk = ~clk;
  function automatic row_t mk(int tag);
    row_t r;
    for (int l = 0; l < LANES; l++) r[l*DATA_W +: DATA_W] = DATA_W'(tag + l * 37);
    return r;
  endfunction
  function automatic row_t rd_row();
    row_t r;
    for (int l = 0; l < LANES; l++) r[l*DATA_W +: DATA_W] = rd_data[l];
    return r;
  endfunction
  task automatic check(string n, row_t act, row_t exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", n, act, exp);
  endtask
  task automatic set_row(int tag);
    row_t r = mk(tag);
    for (int l = 0; l < LANES; l++) wr_data[l] = r[l*DATA_W +: DATA_W];
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk) begin
    bit acc, pp;
    row_t wrow;
    wrow = rd_zero_safe();
    if (rst) begin
      mq.delete(); mtile = 0; mrv = 0; mtl = 0; mdata = '0;
    end else if (flush) begin
      mq.delete(); mtile = 0; mrv = 0; mtl = 0;
    end else begin
      acc = wr_valid && mq.size() < DEPTH;
      pp = rd_en && mq.size() > 0;
      mrv = pp;
      mtl = pp && mtile == TILE_ROWS - 1;
      if (pp) begin
        mdata = mq.pop_front();
        mtile = (mtile + 1) % TILE_ROWS;
      end
      if (acc) mq.push_back(wrow);
    end
  end
  function automatic row_t rd_zero_safe();
    row_t r;
    for (int l = 0; l < LANES; l++) r[l*DATA_W +: DATA_W] = wr_data[l];
    return r;
  endfunction
  always @(negedge clk) if (chk_en) begin
    check("count", row_t'(count), row_t'(mq.size()));
    check("full", row_t'(full), row_t'(mq.size() == DEPTH));
    check("empty", row_t'(empty), row_t'(mq.size() == 0));
    check("almost_full", row_t'(almost_full), row_t'(mq.size() >= DEPTH - AF_MARGIN));
    check("wr_ready", row_t'(wr_ready), row_t'(mq.size() != DEPTH));
    check("rd_valid", row_t'(rd_valid), row_t'(mrv));
    check("tile_last", row_t'(tile_last), row_t'(mtl));
    check("rd_data", rd_row(), mdata);
  end
  initial begin
    set_row(0);
    tick(); tick();
    rst = 0;
    chk_en = 1;
    check("reset_empty", row_t'(empty), row_t'(1));
    check("reset_ready", row_t'(wr_ready), row_t'(1));
    check("reset_data", rd_row(), '0);
    wr_valid = 1;
    for (int i = 0; i < 3; i++) begin set_row(i); tick(); end
    wr_valid = 0;
    check("t1_count3", row_t'(count), row_t'(3));
    rd_en = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_valid", row_t'(rd_valid), row_t'(i < 3));
      check("t1_lane0", row_t'(rd_data[0]), row_t'(i < 3 ? i : 2));
      check("t1_count", row_t'(count), row_t'(i < 3 ? 2 - i : 0));
    end
    rd_en = 0;
    check("t1_empty", row_t'(empty), row_t'(1));
    wr_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      set_row(100 + i);
      tick();
      if (i == 122) check("t2_af_123", row_t'(almost_full), row_t'(0));
      if (i == 123) check("t2_af_124", row_t'(almost_full), row_t'(1));
    end
    check("t2_full", row_t'(full), row_t'(1));
    check("t2_ready", row_t'(wr_ready), row_t'(0));
    set_row(999);
    tick();
    check("t2_count_129th", row_t'(count), row_t'(128));
    rd_en = 1;
    tick();
    rd_en = 0;
    check("t3_count_pop", row_t'(count), row_t'(127));
    check("t3_lane0", row_t'(rd_data[0]), row_t'(100));
    tick();
    check("t3_count_refill", row_t'(count), row_t'(128));
    wr_valid = 0;
    rd_en = 1;
    repeat (118) tick();
    check("t4_count10", row_t'(count), row_t'(10));
    wr_valid = 1;
    for (int i = 0; i < 200; i++) begin set_row(1000 + i); tick(); end
    wr_valid = 0; rd_en = 0;
    check("t4_count_stream", row_t'(count), row_t'(10));
    flush = 1; tick(); flush = 0;
    wr_valid = 1;
    for (int i = 0; i < 64; i++) begin set_row(2000 + i); tick(); end
    wr_valid = 0; rd_en = 1;
    for (int k = 0; k < 64; k++) begin
      tick();
      check("t5_tile_last", row_t'(tile_last), row_t'(k == 31 || k == 63));
    end
    rd_en = 0;
    wr_valid = 1;
    for (int i = 0; i < 50; i++) begin set_row(3000 + i); tick(); end
    check("t6_count50", row_t'(count), row_t'(50));
    set_row(4000); flush = 1; rd_en = 1;
    tick();
    flush = 0; wr_valid = 0; rd_en = 0;
    check("t6_flush_count", row_t'(count), row_t'(0));
    check("t6_flush_empty", row_t'(empty), row_t'(1));
    check("t6_flush_valid", row_t'(rd_valid), row_t'(0));
    wr_valid = 1;
    for (int i = 0; i < 32; i++) begin set_row(5000 + i); tick(); end
    wr_valid = 0; rd_en = 1;
    for (int k = 0; k < 32; k++) begin
      tick();
      check("t6_tile_last", row_t'(tile_last), row_t'(k == 31));
    end
    rd_en = 0;
    wr_valid = 1;
    for (int i = 0; i < 50; i++) begin set_row(6000 + i); tick(); end
    set_row(7000); rst = 1; rd_en = 1;
    tick();
    rst = 0; wr_valid = 0; rd_en = 0;
    check("t7_rst_count", row_t'(count), row_t'(0));
    check("t7_rst_empty", row_t'(empty), row_t'(1));
    check("t7_rst_valid", row_t'(rd_valid), row_t'(0));
    check("t7_rst_data", rd_row(), '0);
    tick(); tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
